// File: rtl/sram_axi_arbiter.sv
// Shares one AXI3 master between the inst (read-only) and data (read/write) sram-like ports.
// Define ARB_RR_EN to replace fixed data-over-inst read priority with round-robin.
module sram_axi_arbiter #(
    parameter int AXI_ID_W = 4,
    parameter int INST_ID  = 0,
    parameter int DATA_ID  = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                inst_req,
    input  logic [1:0]          inst_size,
    input  logic [31:0]         inst_addr,
    output logic                inst_addr_ok,
    output logic                inst_data_ok,
    output logic [31:0]         inst_rdata,
    input  logic                data_req,
    input  logic                data_wr,
    input  logic [1:0]          data_size,
    input  logic [3:0]          data_wen,
    input  logic [31:0]         data_addr,
    input  logic [31:0]         data_wdata,
    output logic                data_addr_ok,
    output logic                data_data_ok,
    output logic [31:0]         data_rdata,
    output logic [AXI_ID_W-1:0] arid,
    output logic [31:0]         araddr,
    output logic [7:0]          arlen,
    output logic [2:0]          arsize,
    output logic                arvalid,
    input  logic                arready,
    input  logic [AXI_ID_W-1:0] rid,
    input  logic [31:0]         rdata,
    input  logic                rvalid,
    output logic                rready,
    output logic [AXI_ID_W-1:0] awid,
    output logic [31:0]         awaddr,
    output logic [7:0]          awlen,
    output logic [2:0]          awsize,
    output logic                awvalid,
    input  logic                awready,
    output logic [31:0]         wdata,
    output logic [3:0]          wstrb,
    output logic                wlast,
    output logic                wvalid,
    input  logic                wready,
    input  logic [AXI_ID_W-1:0] bid,
    input  logic                bvalid,
    output logic                bready
);

    typedef enum logic [1:0] {R_IDLE, R_AR, R_R} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_AW, W_B} w_state_t;

    r_state_t    r_state;
    w_state_t    w_state;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic        r_src;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic [1:0]  w_size;
    logic [3:0]  w_wen;
    logic        data_busy;
    logic        inst_cand;
    logic        data_rd_cand;
    logic        data_wr_cand;
    logic        inst_grant;
    logic        data_grant;
    logic        r_fire;
    logic        b_fire;
    logic        unused_ids;

    // Only one transaction per ID is ever outstanding, so returned IDs carry no information.
    assign unused_ids = ^{rid, bid};

    assign inst_cand    = inst_req && (r_state == R_IDLE);
    assign data_rd_cand = data_req && !data_wr && !data_busy && (r_state == R_IDLE);
    assign data_wr_cand = data_req && data_wr && !data_busy && (w_state == W_IDLE);

`ifdef ARB_RR_EN
    logic last_grant;

    // last_grant: 0 = inst won last, 1 = data won last; the other side wins a conflict.
    assign data_grant = data_rd_cand && (!inst_cand || !last_grant);
    assign inst_grant = inst_cand && (!data_rd_cand || last_grant);

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b0;
        end else if (data_grant) begin
            last_grant <= 1'b1;
        end else if (inst_grant) begin
            last_grant <= 1'b0;
        end
    end
`else
    assign data_grant = data_rd_cand;
    assign inst_grant = inst_cand && !data_rd_cand;
`endif

    assign r_fire       = rready && rvalid;
    assign b_fire       = bready && bvalid;
    assign inst_addr_ok = inst_grant;
    assign data_addr_ok = data_grant || data_wr_cand;
    assign inst_data_ok = r_fire && !r_src;
    assign data_data_ok = (r_fire && r_src) || b_fire;
    assign inst_rdata   = rdata;
    assign data_rdata   = rdata;

    assign arid   = r_src ? AXI_ID_W'(DATA_ID) : AXI_ID_W'(INST_ID);
    assign araddr = r_addr;
    assign arlen  = 8'd0;
    assign arsize = {1'b0, r_size};
    assign awid   = AXI_ID_W'(DATA_ID);
    assign awaddr = w_addr;
    assign awlen  = 8'd0;
    assign awsize = {1'b0, w_size};
    assign wdata  = w_wdata;
    assign wstrb  = w_wen;
    assign wlast  = 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= R_IDLE;
            r_addr  <= 32'd0;
            r_size  <= 2'd0;
            r_src   <= 1'b0;
            arvalid <= 1'b0;
            rready  <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (data_grant || inst_grant) begin
                        r_addr  <= data_grant ? data_addr : inst_addr;
                        r_size  <= data_grant ? data_size : inst_size;
                        r_src   <= data_grant;
                        arvalid <= 1'b1;
                        r_state <= R_AR;
                    end
                end
                R_AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        r_state <= R_R;
                    end
                end
                R_R: begin
                    if (rvalid) begin
                        rready  <= 1'b0;
                        r_state <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // AW and W complete independently; a valid already dropped counts as a finished handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            w_state <= W_IDLE;
            w_addr  <= 32'd0;
            w_size  <= 2'd0;
            w_wen   <= 4'd0;
            w_wdata <= 32'd0;
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            bready  <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (data_wr_cand) begin
                        w_addr  <= data_addr;
                        w_size  <= data_size;
                        w_wen   <= data_wen;
                        w_wdata <= data_wdata;
                        awvalid <= 1'b1;
                        wvalid  <= 1'b1;
                        w_state <= W_AW;
                    end
                end
                W_AW: begin
                    if (awready) awvalid <= 1'b0;
                    if (wready) wvalid <= 1'b0;
                    if ((!awvalid || awready) && (!wvalid || wready)) begin
                        bready  <= 1'b1;
                        w_state <= W_B;
                    end
                end
                W_B: begin
                    if (bvalid) begin
                        bready  <= 1'b0;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_busy <= 1'b0;
        end else if (data_addr_ok) begin
            data_busy <= 1'b1;
        end else if (data_data_ok) begin
            data_busy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sram_axi_arbiter.sv
// Directed bench for sram_axi_arbiter; expectations follow ARB_RR_EN when it is defined.
module tb_sram_axi_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wen;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic [3:0]  arid, rid, awid, bid;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize;
    logic        arvalid, arready, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [3:0]  wstrb;

    int vecCount  = 0;
    int failCount = 0;

    always #5 clk = ~clk;

    sram_axi_arbiter dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wen(data_wen),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bvalid(bvalid), .bready(bready)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vecCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Advance one clock; inputs are then driven 1 time unit after the edge.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    // Entered in the cycle arvalid should be high; handshakes AR then R immediately.
    task automatic serveRead(input logic [31:0] addr, input logic [3:0] id,
                             input logic [31:0] value, input logic isData);
        checkOutput("arvalid", arvalid, 1);
        checkOutput("araddr", araddr, addr);
        checkOutput("arid", arid, id);
        checkOutput("arlen", arlen, 0);
        arready = 1'b1;
        applyStimulus();
        arready = 1'b0;
        rvalid  = 1'b1;
        rdata   = value;
        rid     = id;
        #1;
        checkOutput("rready", rready, 1);
        checkOutput("inst_data_ok", inst_data_ok, !isData);
        checkOutput("data_data_ok", data_data_ok, isData);
        checkOutput(isData ? "data_rdata" : "inst_rdata", isData ? data_rdata : inst_rdata, value);
        applyStimulus();
        rvalid = 1'b0;
        #1;
        checkOutput("rready_drop", rready, 0);
        checkOutput("ok_single_pulse", {inst_data_ok, data_data_ok}, 0);
    endtask

    initial begin
        reset = 1'b1;
        inst_req = 0; inst_size = 0; inst_addr = 0;
        data_req = 0; data_wr = 0; data_size = 0; data_wen = 0; data_addr = 0; data_wdata = 0;
        arready = 0; rid = 0; rdata = 0; rvalid = 0;
        awready = 0; wready = 0; bid = 0; bvalid = 0;
        applyStimulus();
        applyStimulus();
        #1;
        checkOutput("reset_valids", {arvalid, rready, awvalid, wvalid, bready}, 0);
        checkOutput("reset_oks", {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 0);
        applyStimulus();
        reset = 1'b0;

        // Inst read at minimum latency.
        applyStimulus();
        inst_req = 1; inst_addr = 32'hbfc00000; inst_size = 2;
        #1;
        checkOutput("inst_addr_ok_c0", inst_addr_ok, 1);
        checkOutput("data_addr_ok_idle", data_addr_ok, 0);
        applyStimulus();
        inst_req = 0;
        #1;
        checkOutput("arsize_inst", arsize, 3'b010);
        serveRead(32'hbfc00000, 4'd0, 32'h24080001, 0);

        // Simultaneous inst and data reads: data wins, inst waits for R_IDLE.
        applyStimulus();
        inst_req = 1; inst_addr = 32'hbfc00004;
        data_req = 1; data_wr = 0; data_addr = 32'h80000010; data_size = 2;
        #1;
        checkOutput("conflict_data_ok", data_addr_ok, 1);
        checkOutput("conflict_inst_held", inst_addr_ok, 0);
        applyStimulus();
        data_req = 0;
        #1;
        checkOutput("inst_held_r_ar", inst_addr_ok, 0);
        serveRead(32'h80000010, 4'd1, 32'h11112222, 1);
        checkOutput("inst_after_idle", inst_addr_ok, 1);
        applyStimulus();
        inst_req = 0;
        #1;
        serveRead(32'hbfc00004, 4'd0, 32'h33334444, 0);

        // Solo data read makes data the last winner, then a fresh conflict.
        applyStimulus();
        data_req = 1; data_wr = 0; data_addr = 32'h80000014;
        #1;
        checkOutput("solo_data_ok", data_addr_ok, 1);
        applyStimulus();
        data_req = 0;
        #1;
        serveRead(32'h80000014, 4'd1, 32'h55556666, 1);
        inst_req = 1; inst_addr = 32'hbfc00008;
        data_req = 1; data_addr = 32'h80000018;
        #1;
`ifdef ARB_RR_EN
        checkOutput("rr_inst_wins", {inst_addr_ok, data_addr_ok}, 2'b10);
        applyStimulus();
        inst_req = 0; data_req = 0;
        #1;
        serveRead(32'hbfc00008, 4'd0, 32'h77778888, 0);
`else
        checkOutput("fixed_data_wins", {inst_addr_ok, data_addr_ok}, 2'b01);
        applyStimulus();
        inst_req = 0; data_req = 0;
        #1;
        serveRead(32'h80000018, 4'd1, 32'h77778888, 1);
`endif

        // Write with wready at cycle 1 and awready at cycle 3.
        applyStimulus();
        data_req = 1; data_wr = 1; data_addr = 32'h80000020; data_wdata = 32'hdeadbeef;
        data_wen = 4'h3; data_size = 1;
        #1;
        checkOutput("wr_addr_ok", data_addr_ok, 1);
        applyStimulus();
        data_req = 0; wready = 1;
        #1;
        checkOutput("wr_valids_c1", {awvalid, wvalid}, 2'b11);
        checkOutput("awaddr", awaddr, 32'h80000020);
        checkOutput("awsize", awsize, 3'b001);
        checkOutput("awid", awid, 1);
        checkOutput("wdata", wdata, 32'hdeadbeef);
        checkOutput("wstrb_wlast", {wstrb, wlast, awlen}, {4'h3, 1'b1, 8'h00});
        applyStimulus();
        wready = 0;
        #1;
        checkOutput("wr_valids_c2", {awvalid, wvalid}, 2'b10);
        applyStimulus();
        awready = 1;
        #1;
        checkOutput("wr_valids_c3", {awvalid, wvalid, bready}, 3'b100);
        applyStimulus();
        awready = 0;
        #1;
        checkOutput("wr_b_phase", {awvalid, bready, data_data_ok}, 3'b010);
        bvalid = 1;
        #1;
        checkOutput("wr_data_ok", data_data_ok, 1);
        applyStimulus();
        bvalid = 0;
        #1;
        checkOutput("wr_done", {bready, data_data_ok}, 0);

        // Read request behind an outstanding write is held off until its response.
        data_req = 1; data_wr = 1; data_addr = 32'h80000024; data_wen = 4'hf; data_size = 2;
        #1;
        checkOutput("haz_wr_ok", data_addr_ok, 1);
        applyStimulus();
        data_wr = 0; data_addr = 32'h80000030; awready = 1; wready = 1;
        #1;
        checkOutput("haz_rd_held_aw", data_addr_ok, 0);
        applyStimulus();
        awready = 0; wready = 0; bvalid = 1;
        #1;
        checkOutput("haz_rd_held_b", {data_addr_ok, data_data_ok}, 2'b01);
        applyStimulus();
        bvalid = 0;
        #1;
        checkOutput("haz_rd_accepted", data_addr_ok, 1);
        applyStimulus();
        data_req = 0;
        #1;
        serveRead(32'h80000030, 4'd1, 32'h9999aaaa, 1);

        // Inst read and data write together, responses in the same cycle.
        inst_req = 1; inst_addr = 32'hbfc00010;
        data_req = 1; data_wr = 1; data_addr = 32'h80000040; data_wdata = 32'h0badf00d;
        #1;
        checkOutput("conc_accept", {inst_addr_ok, data_addr_ok}, 2'b11);
        applyStimulus();
        inst_req = 0; data_req = 0; arready = 1; awready = 1; wready = 1;
        #1;
        checkOutput("conc_valids", {arvalid, awvalid, wvalid}, 3'b111);
        applyStimulus();
        arready = 0; awready = 0; wready = 0; rvalid = 1; bvalid = 1; rdata = 32'hcafe0001;
        #1;
        checkOutput("conc_oks", {inst_data_ok, data_data_ok}, 2'b11);
        checkOutput("conc_rdata", inst_rdata, 32'hcafe0001);
        applyStimulus();
        rvalid = 0; bvalid = 0;
        #1;
        checkOutput("conc_oks_drop", {inst_data_ok, data_data_ok}, 2'b00);

        // Reset while waiting in R_R abandons the read.
        inst_req = 1; inst_addr = 32'hbfc00020;
        #1;
        checkOutput("rst_req_ok", inst_addr_ok, 1);
        applyStimulus();
        inst_req = 0; arready = 1;
        applyStimulus();
        arready = 0;
        #1;
        checkOutput("rst_in_r_r", rready, 1);
        reset = 1;
        applyStimulus();
        reset = 0; rvalid = 1; inst_req = 1;
        #1;
        checkOutput("rst_rready", rready, 0);
        checkOutput("rst_no_ok", {inst_data_ok, data_data_ok, arvalid}, 0);
        checkOutput("rst_idle", inst_addr_ok, 1);
        inst_req = 0; rvalid = 0;
        applyStimulus();

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
        $finish;
    end

endmodule
